// File: rtl/project_select_pkg.sv
// Shared state encoding, register map and field layout for the project
// select controller and its Wishbone register block.
package project_select_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ON    = 2'd2
  } state_e;

  localparam logic [31:0] OFS_SEL    = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFS_GUARD  = 32'h0000_0008;

  localparam int IDX_W   = 4;
  localparam int GUARD_W = 8;
  localparam int CNT_W   = 8;

  localparam int SEL_IDX_LSB  = 0;
  localparam int SEL_EN_BIT   = 8;

  localparam int STS_CUR_LSB  = 0;
  localparam int STS_ON_BIT   = 8;
  localparam int STS_BUSY_BIT = 9;
  localparam int STS_ERR_BIT  = 10;
  localparam int STS_CNT_LSB  = 16;

endpackage

// File: rtl/project_select_wb_regs.sv
// Wishbone classic slave for the project select block: address decode,
// single-cycle ack, SEL/GUARD registers and the SEL write strobe.
module project_select_wb_regs
  import project_select_pkg::*;
#(
  parameter logic [31:0]        BASE_ADDR = 32'h3000_0000,
  parameter logic [GUARD_W-1:0] GUARD_RST = 8'd4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [31:0]        status_i,
  output logic               sel_wr_o,
  output logic [IDX_W-1:0]   sel_idx_d_o,
  output logic               sel_en_d_o,
  output logic [IDX_W-1:0]   sel_idx_o,
  output logic               sel_en_o,
  output logic [GUARD_W-1:0] guard_o
);

  logic               ack_q;
  logic [31:0]        dat_q;
  logic               armed_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               en_q, en_d;
  logic [GUARD_W-1:0] guard_q, guard_d;

  logic               hit_sel, hit_status, hit_guard;
  logic               req, wr_sel, wr_guard;
  logic [31:0]        rdata;

  always_comb begin
    hit_sel    = (wbs_adr_i == BASE_ADDR + OFS_SEL);
    hit_status = (wbs_adr_i == BASE_ADDR + OFS_STATUS);
    hit_guard  = (wbs_adr_i == BASE_ADDR + OFS_GUARD);
    // A cycle left open across reset is not served until cyc has dropped once.
    req        = wbs_stb_i & wbs_cyc_i & armed_q & ~ack_q &
                 (hit_sel | hit_status | hit_guard);
    wr_sel     = req & wbs_we_i & hit_sel & (|wbs_sel_i);
    wr_guard   = req & wbs_we_i & hit_guard & wbs_sel_i[0];

    idx_d   = idx_q;
    en_d    = en_q;
    guard_d = guard_q;
    if (wr_sel & wbs_sel_i[0]) idx_d = wbs_dat_i[SEL_IDX_LSB +: IDX_W];
    if (wr_sel & wbs_sel_i[1]) en_d  = wbs_dat_i[SEL_EN_BIT];
    if (wr_guard)              guard_d = wbs_dat_i[GUARD_W-1:0];

    rdata = '0;
    if (hit_sel) begin
      rdata[SEL_IDX_LSB +: IDX_W] = idx_q;
      rdata[SEL_EN_BIT]           = en_q;
    end else if (hit_status) begin
      rdata = status_i;
    end else if (hit_guard) begin
      rdata[GUARD_W-1:0] = guard_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      armed_q <= 1'b0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      guard_q <= GUARD_RST;
    end else begin
      ack_q   <= req;
      dat_q   <= (req & ~wbs_we_i) ? rdata : '0;
      armed_q <= armed_q | ~wbs_cyc_i;
      idx_q   <= idx_d;
      en_q    <= en_d;
      guard_q <= guard_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign sel_wr_o    = wr_sel;
  assign sel_idx_d_o = idx_d;
  assign sel_en_d_o  = en_d;
  assign sel_idx_o   = idx_q;
  assign sel_en_o    = en_q;
  assign guard_o     = guard_q;

endmodule

// File: rtl/project_select_ctrl.sv
// Project select controller: switches a one-hot enable between wrapped
// projects with an all-zero guard interval in between.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_OFF   | no project enabled
//   ST_DRAIN | guard interval, all enables low, counter running
//   ST_ON    | project cur_q enabled
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int          N_PROJ    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  GUARD_RST = 8'd4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [N_PROJ-1:0] active_o,
  output logic              irq_o
);

  localparam logic [IDX_W:0] N_LIM = N_PROJ[IDX_W:0];

  state_e             state_q;
  logic [GUARD_W-1:0] cnt_q;
  logic [IDX_W-1:0]   cur_q;
  logic               err_q;
  logic [CNT_W-1:0]   sw_cnt_q;
  logic [N_PROJ-1:0]  active_q;
  logic               irq_q;

  logic               sel_wr;
  logic [IDX_W-1:0]   sel_idx_d, sel_idx;
  logic               sel_en_d, sel_en;
  logic [GUARD_W-1:0] guard;
  logic [31:0]        status;
  logic               wr_idx_ok, wr_noop, tgt_ok;

  project_select_wb_regs #(
    .BASE_ADDR (BASE_ADDR),
    .GUARD_RST (GUARD_RST)
  ) u_regs (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .status_i    (status),
    .sel_wr_o    (sel_wr),
    .sel_idx_d_o (sel_idx_d),
    .sel_en_d_o  (sel_en_d),
    .sel_idx_o   (sel_idx),
    .sel_en_o    (sel_en),
    .guard_o     (guard)
  );

  always_comb begin
    wr_idx_ok = ({1'b0, sel_idx_d} < N_LIM);
    tgt_ok    = sel_en & ({1'b0, sel_idx} < N_LIM);
    // Re-selecting the project that is already running must not glitch it.
    wr_noop   = (state_q == ST_ON) & sel_en_d & (sel_idx_d == cur_q);

    status = '0;
    status[STS_CUR_LSB +: IDX_W] = cur_q;
    status[STS_ON_BIT]           = (state_q == ST_ON);
    status[STS_BUSY_BIT]         = (state_q == ST_DRAIN);
    status[STS_ERR_BIT]          = err_q;
    status[STS_CNT_LSB +: CNT_W] = sw_cnt_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      cur_q    <= '0;
      err_q    <= 1'b0;
      sw_cnt_q <= '0;
      active_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (sel_wr) begin
        if (sel_en_d & ~wr_idx_ok) begin
          err_q <= 1'b1;
        end else if (wr_idx_ok) begin
          err_q <= 1'b0;
        end
        if (!wr_noop) begin
          state_q  <= ST_DRAIN;
          cnt_q    <= guard;
          active_q <= '0;
        end
      end else if (state_q == ST_DRAIN) begin
        if (cnt_q == '0) begin
          irq_q <= 1'b1;
          if (tgt_ok) begin
            state_q  <= ST_ON;
            cur_q    <= sel_idx;
            active_q <= {{(N_PROJ-1){1'b0}}, 1'b1} << sel_idx;
            sw_cnt_q <= sw_cnt_q + 8'd1;
          end else begin
            state_q <= ST_OFF;
          end
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
      end
    end
  end

  assign active_o = active_q;
  assign irq_o    = irq_q;

endmodule

// File: doc/project_select_ctrl.md
PROJECT_SELECT_CTRL -- requirements
Module: project_select_ctrl

Interface
REQ-001 SHALL have parameter N_PROJ, default 8; number of wrapped projects, 2..16.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000; Wishbone base address of the register block.
REQ-003 SHALL have parameter GUARD_RST, default 8'd4; reset value of the settle-cycle register.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write-enable.
REQ-007 SHALL have port wbs_sel_i  in  4  byte-lane enables.
REQ-008 SHALL have ports wbs_adr_i and wbs_dat_i  in  32 each  address and write data.
REQ-009 SHALL have port wbs_ack_o  out  1  Wishbone acknowledge.
REQ-010 SHALL have port wbs_dat_o  out  32  read data.
REQ-011 SHALL have port active_o  out  N_PROJ  one-hot project enable; drives each wrapped project's active input.
REQ-012 SHALL have port irq_o  out  1  switch-complete pulse.

Function
REQ-013 SHALL decode three words: SEL at BASE_ADDR+0x0, STATUS at +0x4, GUARD at +0x8; all other addresses get no ack and have no effect.
REQ-014 SHALL assert wbs_ack_o for exactly one cycle, one cycle after a decoded stb&cyc is sampled with ack low; no back-to-back ack; wbs_dat_o valid with ack, zero otherwise.
REQ-015 SEL fields: [3:0] target index, [8] enable; writes update only byte lanes with wbs_sel_i set; reads return the last written target.
REQ-016 STATUS (read-only) fields: [3:0] current index, [8] on, [9] busy (DRAIN), [10] err sticky, [23:16] switch count; STATUS writes are acked and ignored.
REQ-017 GUARD fields: [7:0] settle cycles; read/write.
REQ-018 FSM states: OFF, DRAIN, ON; active_o is all-zero in OFF and DRAIN and exactly active_o[cur] in ON.
REQ-019 A SEL write (any enabled lane) in any state SHALL enter DRAIN on the acking edge, load the counter with GUARD[7:0], and drive active_o to zero from that edge.
REQ-020 Exception: a SEL write with enable=1 and index equal to cur while in ON SHALL be a no-op; state, active_o and irq_o are unchanged.
REQ-021 In DRAIN, the counter SHALL decrement each cycle; when it is 0, the next edge leaves DRAIN; GUARD=0 gives exactly one all-zero cycle.
REQ-022 On leaving DRAIN: with enable=1 and index<N_PROJ, go to ON with cur=index; otherwise go to OFF.
REQ-023 Index>=N_PROJ with enable=1 SHALL set err and end in OFF; err clears on the next SEL write with a valid index.
REQ-024 A SEL write during DRAIN SHALL replace the target and reload the counter (restart guard).
REQ-025 Switch count SHALL increment, 8-bit wrapping, on each entry to ON.
REQ-026 irq_o SHALL pulse high for one cycle on the edge after leaving DRAIN (to ON or OFF).
REQ-027 GUARD writes during DRAIN SHALL NOT affect the running count.

Reset
REQ-028 Asserting wb_rst_i SHALL immediately, without a clock, force: state OFF, active_o 0, wbs_ack_o 0, wbs_dat_o 0, irq_o 0, SEL 0, GUARD GUARD_RST, cur 0, err 0, count 0.
REQ-029 Reset mid-DRAIN or mid-transaction SHALL abandon the switch and the bus cycle; no ack follows reset release.

Structure
REQ-030 Package project_select_pkg SHALL hold the FSM state enum, register offsets, field bit positions and widths.
REQ-031 Sub-module project_select_wb_regs SHALL contain bus decode, ack and registers, and emit a single-cycle sel_wr strobe to the FSM in project_select_ctrl.

Verification
REQ-032 Reset, write SEL=0x101, GUARD=4 -> active_o 0 for 5 cycles after ack, then active_o=0x02, irq one pulse, STATUS=0x0000_0101+count 1.
REQ-033 In ON idx1, write SEL=0x103 -> active_o 0 same edge as ack, 5 zero cycles, then active_o=0x08; never two bits high.
REQ-034 In ON idx3, write SEL=0x103 -> no change, no irq; write SEL=0x000 -> DRAIN then OFF, irq pulses, active_o stays 0.
REQ-035 Write SEL=0x10F with N_PROJ=8 -> OFF, STATUS[10]=1; write SEL=0x102 -> err clears, ON idx2.
REQ-036 GUARD=0, write SEL=0x100 -> exactly one all-zero cycle; second SEL write mid-DRAIN (GUARD=6) restarts count, and the final index is from the second write.
REQ-037 Assert wb_rst_i mid-DRAIN and mid-bus-cycle -> all outputs 0 asynchronously, GUARD reads 4, no ack after release.
